// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer: command op codes, datapath shift modes and FSM states.
package shift_seq_pkg;

    localparam logic [1:0] OP_TX_MSB = 2'b00;
    localparam logic [1:0] OP_TX_LSB = 2'b01;
    localparam logic [1:0] OP_RX_MSB = 2'b10;
    localparam logic [1:0] OP_RX_LSB = 2'b11;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Op code bit 1 selects receive, bit 0 selects LSB-first ordering.
    function automatic logic op_is_rx(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_lsb(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Bus-side command/receive handshakes plus the serial link pins of the shift sequencer.
interface shift_seq_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             ser_in;
    logic             ser_out;
    logic             bit_strobe;
    logic             busy;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, ser_in, rx_ready,
        input  cmd_ready, ser_out, bit_strobe, busy, rx_valid, rx_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, ser_in, rx_ready,
        output cmd_ready, ser_out, bit_strobe, busy, rx_valid, rx_data
    );
endinterface

// File: rtl/shift_sequencer_datapath.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or parallel load.
module shift_datapath
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             left_in,
    input  logic             right_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // left_in enters at the MSB on a right shift, right_in enters at bit 0 on a left shift.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic from_upper;
        logic from_lower;

        if (gi == WIDTH - 1) begin : g_top
            assign from_upper = left_in;
        end else begin : g_mid_upper
            assign from_upper = q_reg[gi+1];
        end

        if (gi == 0) begin : g_bottom
            assign from_lower = right_in;
        end else begin : g_mid_lower
            assign from_lower = q_reg[gi-1];
        end

        assign q_next[gi] = (mode == MODE_HOLD)  ? q_reg[gi] :
                            (mode == MODE_RIGHT) ? from_upper :
                            (mode == MODE_LEFT)  ? from_lower :
                                                   load_data[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a universal shift datapath to run serial TX and RX transactions at DIV clocks per bit.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    shift_seq_if.slave  bus
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [1:0]       op_reg, op_next;

    logic [1:0]       mode;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] q;
    logic             shift_in;
    logic             tick;
    logic             last_bit;
    logic             accept;

    // With DIV=1 every SHIFT cycle is a bit boundary and div_cnt never leaves 0.
    assign tick     = (DIV == 1) ? 1'b1 : (div_cnt_reg == DIV_W'(DIV - 1));
    assign last_bit = (bit_cnt_reg == BIT_W'(WIDTH - 1));
    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign shift_in = op_is_rx(op_reg) ? bus.ser_in : 1'b0;

    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        op_next      = op_reg;
        mode         = MODE_HOLD;
        load_data    = '0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    op_next      = bus.cmd_op;
                    div_cnt_next = '0;
                    bit_cnt_next = '0;
                    mode         = MODE_LOAD;
                    load_data    = op_is_rx(bus.cmd_op) ? '0 : bus.cmd_data;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    div_cnt_next = '0;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    mode         = op_is_lsb(op_reg) ? MODE_RIGHT : MODE_LEFT;
                    if (last_bit) begin
                        state_next = op_is_rx(op_reg) ? ST_DONE : ST_IDLE;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.rx_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            op_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            op_reg      <= op_next;
        end
    end

    shift_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .load_data (load_data),
        .left_in   (shift_in),
        .right_in  (shift_in),
        .q         (q)
    );

    assign bus.cmd_ready  = (state_reg == ST_IDLE) && !reset;
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.bit_strobe = (state_reg == ST_SHIFT) && tick;
    assign bus.rx_valid   = (state_reg == ST_DONE);
    assign bus.rx_data    = q;
    assign bus.ser_out    = (state_reg == ST_SHIFT && !op_is_rx(op_reg)) ?
                            (op_is_lsb(op_reg) ? q[0] : q[WIDTH-1]) : 1'b0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: DIV=2 and DIV=1 instances of the shift sequencer with hand-computed expectations.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   checks;
    int   errors;

    shift_seq_if #(.WIDTH(4)) ifa ();
    shift_seq_if #(.WIDTH(4)) ifb ();

    shift_sequencer #(.WIDTH(4), .DIV(2)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ifa.slave)
    );

    shift_sequencer #(.WIDTH(4), .DIV(1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command on the DIV=2 instance; returns positioned in the first SHIFT cycle.
    task automatic issue_a(input string tag, input logic [1:0] op, input logic [3:0] data);
        ifa.cmd_valid = 1'b1;
        ifa.cmd_op    = op;
        ifa.cmd_data  = data;
        #1;
        chk({tag, "_ready_before"}, ifa.cmd_ready, 1'b1);
        step();
        ifa.cmd_valid = 1'b0;
        $display("cmd %s op=%0d data=%b accepted", tag, op, data);
    endtask

    // Walk the 8 SHIFT cycles of the DIV=2 instance, driving ser_in per bit period.
    task automatic run_bits_a(input string tag, input logic [7:0] ser_exp,
                              input logic [7:0] strobe_exp, input logic [3:0] rx_bits);
        for (int k = 1; k <= 8; k++) begin
            ifa.ser_in = rx_bits[3 - (k - 1) / 2];
            #1;
            chk({tag, "_ser_out"},    ifa.ser_out,    ser_exp[8 - k]);
            chk({tag, "_bit_strobe"}, ifa.bit_strobe, strobe_exp[8 - k]);
            chk({tag, "_busy"},       ifa.busy,       1'b1);
            chk({tag, "_cmd_ready"},  ifa.cmd_ready,  1'b0);
            step();
        end
        ifa.ser_in = 1'b0;
    endtask

    initial begin
        logic [7:0] strobe2;
        logic [3:0] pat;
        checks = 0;
        errors = 0;
        strobe2 = 8'b0101_0101;

        ifa.cmd_valid = 1'b0; ifa.cmd_op = 2'b00; ifa.cmd_data = '0;
        ifa.ser_in = 1'b0;    ifa.rx_ready = 1'b0;
        ifb.cmd_valid = 1'b0; ifb.cmd_op = 2'b00; ifb.cmd_data = '0;
        ifb.ser_in = 1'b0;    ifb.rx_ready = 1'b0;
        reset_a = 1'b1;
        reset_b = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_ser_out",  ifa.ser_out,    1'b0);
        chk("rst_busy",     ifa.busy,       1'b0);
        chk("rst_rx_valid", ifa.rx_valid,   1'b0);
        chk("rst_strobe",   ifa.bit_strobe, 1'b0);
        chk("rst_rx_data",  ifa.rx_data,    4'b0000);
        chk("rst_ready_in_reset", ifa.cmd_ready, 1'b0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        chk("rst_ready_after", ifa.cmd_ready, 1'b1);
        chk("rst_ready_after_b", ifb.cmd_ready, 1'b1);
        step();

        // 1: TX_MSB 1100
        issue_a("tx_msb", OP_TX_MSB, 4'b1100);
        run_bits_a("tx_msb", 8'b1111_0000, strobe2, 4'b0000);
        chk("tx_msb_ready_end", ifa.cmd_ready, 1'b1);
        chk("tx_msb_ser_idle",  ifa.ser_out,   1'b0);
        $display("tx_msb done");

        // 2: TX_LSB 1100
        issue_a("tx_lsb", OP_TX_LSB, 4'b1100);
        run_bits_a("tx_lsb", 8'b0000_1111, strobe2, 4'b0000);
        chk("tx_lsb_ser_idle",  ifa.ser_out,   1'b0);
        chk("tx_lsb_busy_end",  ifa.busy,      1'b0);
        chk("tx_lsb_ready_end", ifa.cmd_ready, 1'b1);
        $display("tx_lsb done");

        // 3: RX_MSB with bits 1,0,1,1
        issue_a("rx_msb", OP_RX_MSB, 4'b1111);
        run_bits_a("rx_msb", 8'b0000_0000, strobe2, 4'b1011);
        chk("rx_msb_valid",   ifa.rx_valid,  1'b1);
        chk("rx_msb_data",    ifa.rx_data,   4'b1011);
        chk("rx_msb_busy",    ifa.busy,      1'b1);
        chk("rx_msb_ready",   ifa.cmd_ready, 1'b0);
        ifa.rx_ready = 1'b1;
        step();
        ifa.rx_ready = 1'b0;
        chk("rx_msb_valid_clr", ifa.rx_valid,  1'b0);
        chk("rx_msb_idle",      ifa.cmd_ready, 1'b1);
        $display("rx_msb done data=1011");

        // 3/4: RX_LSB, then stall rx_ready low for 5 cycles with a stray command
        issue_a("rx_lsb", OP_RX_LSB, 4'b0000);
        run_bits_a("rx_lsb", 8'b0000_0000, strobe2, 4'b1011);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ifa.cmd_valid = 1'b1;
                ifa.cmd_op    = OP_TX_MSB;
                ifa.cmd_data  = 4'b1111;
            end
            #1;
            chk("stall_valid", ifa.rx_valid,  1'b1);
            chk("stall_data",  ifa.rx_data,   4'b1101);
            chk("stall_ready", ifa.cmd_ready, 1'b0);
            step();
            ifa.cmd_valid = 1'b0;
        end
        ifa.rx_ready = 1'b1;
        #1;
        chk("release_valid", ifa.rx_valid, 1'b1);
        step();
        ifa.rx_ready = 1'b0;
        chk("release_valid_clr", ifa.rx_valid,  1'b0);
        chk("release_busy",      ifa.busy,      1'b0);
        chk("release_ready",     ifa.cmd_ready, 1'b1);
        step();
        chk("stray_cmd_ignored", ifa.busy, 1'b0);
        $display("rx_lsb done data=1101 after stall");

        // 5: reset in the middle of a TX, then a clean TX_MSB 1010
        issue_a("abort", OP_TX_MSB, 4'b1100);
        step();
        step();
        reset_a = 1'b1;
        #1;
        chk("abort_ready_in_reset", ifa.cmd_ready, 1'b0);
        step();
        chk("abort_ser_out", ifa.ser_out, 1'b0);
        chk("abort_busy",    ifa.busy,    1'b0);
        reset_a = 1'b0;
        #1;
        chk("abort_ready_after", ifa.cmd_ready, 1'b1);
        step();
        issue_a("post_abort", OP_TX_MSB, 4'b1010);
        run_bits_a("post_abort", 8'b1100_1100, strobe2, 4'b0000);
        chk("post_abort_ready", ifa.cmd_ready, 1'b1);
        $display("abort and retransmit done");

        // 6: DIV=1 back-to-back TX_MSB 1001 then 0110 with cmd_valid held
        ifb.cmd_valid = 1'b1;
        ifb.cmd_op    = OP_TX_MSB;
        ifb.cmd_data  = 4'b1001;
        #1;
        chk("b2b_ready_first", ifb.cmd_ready, 1'b1);
        step();
        ifb.cmd_data = 4'b0110;
        pat = 4'b1001;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("b2b_first_ser",    ifb.ser_out,    pat[4 - k]);
            chk("b2b_first_strobe", ifb.bit_strobe, 1'b1);
            chk("b2b_first_ready",  ifb.cmd_ready,  1'b0);
            step();
        end
        chk("b2b_gap_ready",  ifb.cmd_ready,  1'b1);
        chk("b2b_gap_ser",    ifb.ser_out,    1'b0);
        chk("b2b_gap_strobe", ifb.bit_strobe, 1'b0);
        step();
        ifb.cmd_valid = 1'b0;
        pat = 4'b0110;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("b2b_second_ser",    ifb.ser_out,    pat[4 - k]);
            chk("b2b_second_strobe", ifb.bit_strobe, 1'b1);
            step();
        end
        chk("b2b_end_ready", ifb.cmd_ready, 1'b1);
        chk("b2b_end_busy",  ifb.busy,      1'b0);
        $display("back-to-back DIV=1 done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that sequences a WIDTH-bit universal shift datapath to run serial transmit and serial receive transactions.
- Accepts one command per valid/ready handshake and drives the 2-bit shift mode (hold/right/left/load) with a bit-rate divider and a bit counter.
- For TX it serializes a parallel word onto ser_out; for RX it deserializes ser_in and returns the word through a valid/ready handshake.
- Sits between a parallel bus-side client and a single-wire serial link.

Parameters:
- WIDTH, 4, word length in bits (>=2).
- DIV, 4, clock cycles per serial bit (>=1); DIV=1 means one bit per cycle.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_op  in  2  00 TX_MSB, 01 TX_LSB, 10 RX_MSB, 11 RX_LSB.
- cmd_data  in  WIDTH  TX word (ignored for RX ops).
- ser_in  in  1  serial receive line.
- ser_out  out  1  serial transmit line.
- bit_strobe  out  1  one-cycle pulse on the last cycle of each bit period in SHIFT.
- busy  out  1  high in SHIFT or DONE.
- rx_valid  out  1  received word available.
- rx_ready  in  1  consumer accepts rx_data.
- rx_data  out  WIDTH  received word.

Behaviour:
- Clock and reset: single clk; reset is synchronous and active-high. Reset overrides everything, including a transaction in flight, and aborts it with no partial output. After the reset edge: state=IDLE, shift register=0, div_cnt=0, bit_cnt=0, op=0, ser_out=0, bit_strobe=0, rx_valid=0, busy=0.
- Handshake gating: cmd_ready = (state==IDLE) && !reset. Combinational, and independent of cmd_valid.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Datapath mode is hold.
  - On the accept edge: register op, and clear div_cnt and bit_cnt.
  - TX op: datapath loads cmd_data (mode 11).
  - RX op: datapath loads all-zeros (mode 11).
  - Next state is SHIFT.
- SHIFT:
  - div_cnt counts 0..DIV-1 and wraps. tick = (div_cnt==DIV-1), and bit_strobe = tick.
  - On each tick, bit_cnt increments.
  - The datapath holds whenever tick is low.
- TX_MSB: ser_out = reg[WIDTH-1]. On tick, shift left (mode 10) with 0 filled at bit 0.
- TX_LSB: ser_out = reg[0]. On tick, shift right (mode 01) with 0 filled at MSB.
- RX_MSB: on tick, sample ser_in and shift left, inserting it at bit 0.
- RX_LSB: on tick, sample ser_in and shift right, inserting it at bit WIDTH-1.
- End of SHIFT: on the tick where bit_cnt==WIDTH-1:
  - TX goes to IDLE.
  - RX goes to DONE.
- TX latency:
  - Handshake edge T. First bit drives ser_out from cycle T+1.
  - Each bit is held DIV cycles.
  - cmd_ready is high again at cycle T+1+WIDTH*DIV.
- ser_out is 0 whenever the block is not in a TX SHIFT.
- DONE:
  - rx_valid=1 and rx_data=reg; the datapath holds.
  - Data is stable while rx_ready is low, with no bound on the stall.
  - On rx_valid && rx_ready, go to IDLE on the next edge.
  - rx_valid=0 in every other state.
- Back-to-back commands:
  - A new command can be accepted in the first IDLE cycle after TX completes.
  - Maximum TX throughput is one word per WIDTH*DIV+1 cycles.
- Outside DONE, rx_data reflects the register and is don't-care.
- cmd_valid, and any change to cmd_op or cmd_data, while not in IDLE is ignored.
- Counter widths: $clog2(DIV) and $clog2(WIDTH), minimum 1 bit. div_cnt is held at 0 when DIV=1.

Decomposition:
- Shared package shift_seq_pkg:
  - op codes: OP_TX_MSB, OP_TX_LSB, OP_RX_MSB, OP_RX_LSB.
  - shift-mode constants: MODE_HOLD=00, MODE_RIGHT=01, MODE_LEFT=10, MODE_LOAD=11.
  - state enum: IDLE, SHIFT, DONE.
- Sub-module shift_datapath:
  - WIDTH-bit universal register with the same mode encoding, synchronous active-high reset, separate left-side and right-side serial inputs, and a parallel load input.
  - The sequencer owns the FSM, counters and handshakes, and drives shift_datapath's mode and serial inputs.

Test Plan:
1. WIDTH=4, DIV=2, TX_MSB, cmd_data=4'b1100 accepted at T -> ser_out 1,1,0,0, each held 2 cycles from T+1. bit_strobe pulses at T+2, T+4, T+6, T+8. cmd_ready high again at T+9.
2. Same setup, TX_LSB 4'b1100 -> ser_out 0,0,1,1. ser_out=0 after completion. busy low at T+9.
3. RX_MSB with ser_in bits 1,0,1,1 stable across each bit period -> rx_valid at T+9 with rx_data=4'b1011. RX_LSB with the same stimulus -> rx_data=4'b1101.
4. RX completes with rx_ready held low 5 cycles -> rx_valid and rx_data stay constant. A cmd_valid pulse meanwhile is not accepted (cmd_ready=0). rx_ready=1 -> IDLE next cycle.
5. Reset asserted during bit 2 of a TX -> next edge: ser_out=0, busy=0, cmd_ready=1 after reset drops. A new TX_MSB 4'b1010 then runs cleanly as 1,0,1,0.
6. DIV=1, two TX_MSB commands back-to-back (4'b1001, then 4'b0110) with cmd_valid held -> ser_out 1,0,0,1 then, after one IDLE cycle, 0,1,1,0. bit_strobe high every SHIFT cycle.
